// File: rtl/multi_sync_edge.sv
// N-channel synchroniser for asynchronous level/flag inputs.
// Each channel has a flop chain, an optional stability filter and an edge-pulse detector.
module multi_sync_edge #(
  parameter int   CHANNELS   = 4,
  parameter int   STAGES     = 2,
  parameter int   FILTER_CYC = 0,
  parameter int   EDGE_MODE  = 0,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] edge_pulse,
  output logic                any_edge
);

  // Reject parameter sets the structure cannot implement.
  if (STAGES < 2) begin : g_bad_stages
    $error("multi_sync_edge: STAGES must be >= 2");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("multi_sync_edge: CHANNELS must be >= 1");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
    $error("multi_sync_edge: EDGE_MODE must be 0, 1 or 2");
  end
  if (FILTER_CYC < 0) begin : g_bad_filter
    $error("multi_sync_edge: FILTER_CYC must be >= 0");
  end

  localparam int unsigned          NSTAGES  = STAGES;
  localparam logic [CHANNELS-1:0]  RST_FILL = {CHANNELS{RESET_VAL}};

  logic [CHANNELS-1:0] chain_q [STAGES];
  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] hist_q;

  // Synchroniser chain: only the first stage sees the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NSTAGES; k++) begin
        chain_q[k] <= RST_FILL;
      end
    end else begin
      chain_q[0] <= async_in;
      for (int unsigned k = 1; k < NSTAGES; k++) begin
        chain_q[k] <= chain_q[k-1];
      end
    end
  end

  assign raw = chain_q[STAGES-1];

  if (FILTER_CYC == 0) begin : g_nofilt
    assign sync_out = raw;
  end else begin : g_filt
    localparam int             CW       = $clog2(FILTER_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYC - 1);

    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] filt_q;
    logic [CHANNELS-1:0] filt_d;

    // Count consecutive cycles the chain output disagrees with the filtered level.
    always_comb begin
      filt_d = filt_q;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_d[i] = '0;
        if (raw[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = raw[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    // Filter state register; reset discards any partial count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        filt_q <= RST_FILL;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        filt_q <= filt_d;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end

    assign sync_out = filt_q;
  end

  // Edge history: previous cycle's synchronised level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= RST_FILL;
    end else begin
      hist_q <= sync_out;
    end
  end

  // Edge pulses are decoded from flop outputs only, so they are glitch-free.
  always_comb begin
    edge_pulse = '0;
    case (EDGE_MODE)
      0:       edge_pulse = sync_out & ~hist_q;
      1:       edge_pulse = ~sync_out & hist_q;
      default: edge_pulse = sync_out ^ hist_q;
    endcase
  end

  assign any_edge = |edge_pulse;

endmodule
